// File: rtl/interp_fir_polyphase.sv
// Polyphase interpolating FIR: each accepted sample yields L output phases,
// each computed by a serial signed MAC over a runtime-loadable coefficient bank.
module interp_fir_polyphase #(
   parameter  int DATA_W         = 8,
   parameter  int COEF_W         = 8,
   parameter  int L              = 2,
   parameter  int TAPS_PER_PHASE = 4,
   parameter  int OUT_W          = 16,
   parameter  int SHIFT          = 0,
   localparam int N              = L * TAPS_PER_PHASE,
   localparam int AW             = (N > 1) ? $clog2(N) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] dataIn,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [OUT_W-1:0]  dataOut,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     coef_we,
   input  logic        [AW-1:0]     coef_addr,
   input  logic signed [COEF_W-1:0] coef_data
);

   localparam int T      = TAPS_PER_PHASE;
   localparam int KW     = (T > 1) ? $clog2(T) : 1;
   localparam int PW     = (L > 1) ? $clog2(L) : 1;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = DATA_W + COEF_W + $clog2(T) + 1;
   localparam int EW     = (ACC_W > OUT_W) ? ACC_W : OUT_W;

   localparam logic        [AW:0]      N_EXT    = (AW + 1)'(N);
   // (1<<SHIFT)>>1 is the half-LSB bias for SHIFT>0 and zero for SHIFT=0
   localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'((1 << SHIFT) >> 1);
   localparam logic signed [EW-1:0]    SAT_MAX  = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EW-1:0]    SAT_MIN  = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                    state;
   logic signed [DATA_W-1:0]  x [T];
   logic signed [COEF_W-1:0]  h [N];
   logic signed [ACC_W-1:0]   acc;
   logic        [KW-1:0]      k;
   logic        [PW-1:0]      phase;

   logic        [AW-1:0]      idx;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   acc_nxt;

   function automatic logic signed [ACC_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
      return (a + RND_BIAS) >>> SHIFT;
   endfunction

   function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
      logic signed [EW-1:0] v;
      v = EW'(a);
      if (v > SAT_MAX)
         return SAT_MAX[OUT_W-1:0];
      else if (v < SAT_MIN)
         return SAT_MIN[OUT_W-1:0];
      else
         return v[OUT_W-1:0];
   endfunction

   assign in_ready = (state == IDLE);

   // Tap k of phase p uses h[k*L + p]; x[0] is the newest sample.
   assign idx     = AW'(int'(k) * L + int'(phase));
   assign prod    = PROD_W'(x[k]) * PROD_W'(h[idx]);
   assign acc_nxt = acc + ACC_W'(prod);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         for (int i = 0; i < T; i++) x[i] <= '0;
         for (int i = 0; i < N; i++) h[i] <= '0;
         acc       <= '0;
         k         <= '0;
         phase     <= '0;
         dataOut   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A same-cycle coefficient write lands before the next MAC pass reads it.
               if (coef_we && ({1'b0, coef_addr} < N_EXT))
                  h[coef_addr] <= coef_data;
               if (in_valid) begin
                  for (int i = T - 1; i > 0; i--) x[i] <= x[i-1];
                  x[0]  <= dataIn;
                  phase <= '0;
                  k     <= '0;
                  acc   <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc_nxt;
               k   <= k + 1'b1;
               if (k == KW'(T - 1))
                  state <= OUT;
            end
            OUT: begin
               // First OUT cycle registers the result; afterwards hold until accepted.
               if (!out_valid) begin
                  dataOut   <= sat_out(round_acc(acc));
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  if (phase == PW'(L - 1)) begin
                     state <= IDLE;
                  end else begin
                     phase <= phase + 1'b1;
                     k     <= '0;
                     acc   <= '0;
                     state <= MAC;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interp_fir_polyphase.sv
// Directed bench for interp_fir_polyphase: impulse, timing, backpressure,
// saturation, rounding (SHIFT=2 instance), coefficient guard and async reset.
module tb_interp_fir_polyphase;

   logic              clk = 1'b0;
   logic              reset;
   logic signed [7:0] dataIn;
   logic              in_valid;
   logic              in_ready, in_ready_s2;
   logic signed [15:0] dataOut, dataOut_s2;
   logic              out_valid, out_valid_s2;
   logic              out_ready;
   logic              coef_we;
   logic [2:0]        coef_addr;
   logic signed [7:0] coef_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   interp_fir_polyphase #(
      .DATA_W(8), .COEF_W(8), .L(2), .TAPS_PER_PHASE(4), .OUT_W(16), .SHIFT(0)
   ) u_dut (
      .clk(clk), .reset(reset), .dataIn(dataIn), .in_valid(in_valid), .in_ready(in_ready),
      .dataOut(dataOut), .out_valid(out_valid), .out_ready(out_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
   );

   interp_fir_polyphase #(
      .DATA_W(8), .COEF_W(8), .L(2), .TAPS_PER_PHASE(4), .OUT_W(16), .SHIFT(2)
   ) u_dut_s2 (
      .clk(clk), .reset(reset), .dataIn(dataIn), .in_valid(in_valid), .in_ready(in_ready_s2),
      .dataOut(dataOut_s2), .out_valid(out_valid_s2), .out_ready(out_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic write_coef(input int a, input int d);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 3'(a);
      coef_data = 8'(d);
      @(negedge clk);
      coef_we   = 1'b0;
   endtask

   // Presents one sample; with poke set, also pulses a coefficient write during MAC.
   task automatic send(input int v, input bit poke);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      dataIn   = 8'(v);
      @(negedge clk);
      in_valid = 1'b0;
      if (poke) begin
         coef_we   = 1'b1;
         coef_addr = 3'd5;
         coef_data = 8'sd77;
         @(negedge clk);
         coef_we   = 1'b0;
      end
   endtask

   // Called on a negedge with out_ready=1; returns after the handshake edge.
   task automatic get_out(output int v, output int v2);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
      v  = dataOut;
      v2 = dataOut_s2;
      @(negedge clk);
   endtask

   task automatic run_sample(input int v, input int e0, input int e1, input string tag);
      int a, b;
      send(v, 1'b0);
      get_out(a, b);
      check({tag, "_p0"}, a, e0);
      get_out(a, b);
      check({tag, "_p1"}, a, e1);
   endtask

   initial begin
      int a, b, edges, n;
      reset     = 1'b1;
      in_valid  = 1'b0;
      dataIn    = '0;
      out_ready = 1'b1;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;

      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_dataOut", dataOut, 0);
      check("rst_in_ready", in_ready, 1);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) write_coef(i, i + 1);

      // Timing on the first impulse sample
      @(negedge clk);
      in_valid = 1'b1;
      dataIn   = 8'sd1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_after_accept", in_ready, 0);
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("lat_first", edges, 5);
      check("imp0_p0", dataOut, 1);
      check("busy_out0", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      check("ov_drop", out_valid, 0);
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("lat_second", edges, 5);
      check("imp0_p1", dataOut, 2);
      check("busy_out1", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      check("in_ready_back", in_ready, 1);

      // Backpressure, with coefficient writes attempted in MAC and OUT
      out_ready = 1'b0;
      send(0, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid", out_valid, 1);
      check("bp_first", dataOut, 3);
      for (int i = 0; i < 10; i++) begin
         in_valid  = i[0];
         dataIn    = 8'sd55;
         coef_we   = (i == 3);
         coef_addr = 3'd2;
         coef_data = 8'sd99;
         @(negedge clk);
         check("bp_hold_data", dataOut, 3);
         check("bp_hold_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      coef_we   = 1'b0;
      out_ready = 1'b1;
      get_out(a, b);
      check("bp_p0", a, 3);
      get_out(a, b);
      check("bp_p1", a, 4);
      run_sample(0, 5, 6, "imp2");
      run_sample(0, 7, 8, "imp3");
      run_sample(0, 0, 0, "imp4");

      // Guarded writes must have left the bank intact
      run_sample(1, 1, 2, "guard0");
      run_sample(0, 3, 4, "guard1");
      run_sample(0, 5, 6, "guard2");
      run_sample(0, 7, 8, "guard3");

      // Saturation: all h=127, inputs of -128
      for (int i = 0; i < 8; i++) write_coef(i, 127);
      run_sample(-128, -16256, -16256, "sat1");
      run_sample(-128, -32512, -32512, "sat2");
      run_sample(-128, -32768, -32768, "sat3");
      run_sample(-128, -32768, -32768, "sat4");

      // Asynchronous reset during MAC of the second phase
      send(-128, 1'b0);
      get_out(a, b);
      check("pre_reset_p0", a, -32768);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_dataOut", dataOut, 0);
      check("arst_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      run_sample(1, 0, 0, "cleared");

      // Rounding on the SHIFT=2 instance; the SHIFT=0 instance passes through
      write_coef(0, 1);
      send(6, 1'b0);
      get_out(a, b);
      check("raw_pos", a, 6);
      check("rnd_pos", b, 2);
      get_out(a, b);
      check("rnd_pos_p1", b, 0);
      send(-6, 1'b0);
      get_out(a, b);
      check("raw_neg", a, -6);
      check("rnd_neg", b, -1);
      get_out(a, b);
      check("rnd_neg_p1", b, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/interp_fir_polyphase.md
Name: interp_fir_polyphase

Overview:
- Parametrised polyphase interpolating FIR: every accepted input sample yields L output samples (phases 0..L-1).
- Each phase is computed on a serial signed MAC over a runtime-loadable coefficient bank.
- Valid/ready handshakes on both sides and rounded, saturated output.
- Sits between the sample source and the sigma-delta modulator, replacing the fixed 4-tap single-rate filter stage.

Parameters:
- DATA_W, 8, input sample width (signed two's complement).
- COEF_W, 8, coefficient width (signed).
- L, 2, interpolation factor (number of phases), >=1.
- TAPS_PER_PHASE, 4, taps per phase (T); total taps N = L*T.
- OUT_W, 16, output width (signed).
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dataIn  in  DATA_W  input sample (signed).
- in_valid  in  1  dataIn valid.
- in_ready  out  1  block can accept a sample.
- dataOut  out  OUT_W  interpolated output sample (signed).
- out_valid  out  1  dataOut valid.
- out_ready  in  1  downstream accepts dataOut.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(N)  coefficient index n, 0..N-1.
- coef_data  in  COEF_W  coefficient value (signed).

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; delay line x[0..T-1]=0; all N coefficients=0; accumulator=0; phase=0; tap counter=0.
  - dataOut=0, out_valid=0, in_ready=1 (combinational from IDLE).
  - A reset in the middle of a MAC or OUT state discards the in-progress sample with no partial output.
- Registered FSM states: IDLE, MAC, OUT. in_ready = (state==IDLE).
- IDLE:
  - On in_valid & in_ready: x[k] <= x[k-1] for k=T-1..1, x[0] <= dataIn; phase=0, k=0, acc=0; go to MAC.
- MAC (exactly T cycles):
  - Each cycle: acc <= acc + x[k]*h[k*L+phase]; k++.
  - After the cycle with k==T-1, go to OUT.
  - On entry to OUT, dataOut <= sat(round(acc)) and out_valid <= 1.
- OUT:
  - dataOut and out_valid are held stable while out_ready=0.
  - On out_valid & out_ready with phase<L-1: phase++, k=0, acc=0, out_valid <= 0, go to MAC.
  - On out_valid & out_ready with phase==L-1: out_valid <= 0, go to IDLE.
- Latency: input accepted on edge E0; first out_valid high after edge E(T+1). With out_ready=1, each later phase follows T+1 edges after the previous handshake. in_ready returns one cycle after the last phase handshake.
- Arithmetic:
  - All operands are signed; products are DATA_W+COEF_W bits.
  - acc width = DATA_W+COEF_W+clog2(T)+1, so no overflow is possible.
  - round: if SHIFT>0, add 2^(SHIFT-1) then arithmetic shift right by SHIFT; if SHIFT=0, pass through.
  - sat: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Coefficient load:
  - Write takes effect only when coef_we=1, state==IDLE and coef_addr<N.
  - Writes are ignored in any other state or with an out-of-range address.
  - If a write and an input acceptance occur in the same IDLE cycle, the write lands first and is used by that sample's MACs.
- dataIn is ignored when in_ready=0. The delay line changes only on input acceptance.

Test Plan:
- Impulse: load h[n]=n+1 for n=0..7 (default params, SHIFT=0); inputs 1,0,0,0 with out_ready=1 -> dataOut sequence 1,2,3,4,5,6,7,8; the next input 0 yields 0,0.
- Timing: accept at E0 -> out_valid first high after E5 (T+1=5); the second phase follows 5 edges after the first handshake; in_ready stays low from E1 until one cycle after the second handshake.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> dataOut and out_valid stable, in_ready=0, in_valid pulses ignored, delay line unchanged; release -> sequence continues intact.
- Saturation and rounding:
  - all h=127, four inputs of -128 -> phase output -65024 saturates to -32768 (0x8000).
  - SHIFT=2 rebuild, h[0]=1 others 0, input 6 -> (6+2)>>>2 = 2.
  - input -6 -> (-6+2)>>>2 = -1.
- Coefficient guard: a coef_we pulse during MAC or OUT, and a write to addr>=N -> coefficient bank unchanged (re-run impulse gives 1..8).
- Reset mid-operation: assert reset during MAC of the second phase -> out_valid=0, dataOut=0, in_ready=1 immediately (asynchronous); coefficients cleared; a subsequent impulse outputs all zeros until reloaded.
